// File: rtl/id_ex_pipe_stage.sv
// ID/EX pipeline register with valid bit, control bundle, stall/flush handling,
// load-use hazard detection with bubble insertion and saturating perf counters.
module id_ex_pipe_stage #(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 5,
    parameter int FUNCT_W     = 6,
    parameter int CTRL_W      = 10,
    parameter int MEMREAD_BIT = 5,
    parameter int CNT_W       = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush_in,
    input  logic               stall_in,
    input  logic               id_valid,
    input  logic [DATA_W-1:0]  id_pc_incr,
    input  logic [DATA_W-1:0]  id_rd1,
    input  logic [DATA_W-1:0]  id_rd2,
    input  logic [DATA_W-1:0]  id_imm,
    input  logic [ADDR_W-1:0]  id_rs,
    input  logic [ADDR_W-1:0]  id_rt,
    input  logic [ADDR_W-1:0]  id_rd,
    input  logic               id_uses_rt,
    input  logic [FUNCT_W-1:0] id_funct,
    input  logic [CTRL_W-1:0]  id_ctrl,
    output logic               ex_valid,
    output logic [DATA_W-1:0]  ex_pc_incr,
    output logic [DATA_W-1:0]  ex_rd1,
    output logic [DATA_W-1:0]  ex_rd2,
    output logic [DATA_W-1:0]  ex_imm,
    output logic [ADDR_W-1:0]  ex_rs,
    output logic [ADDR_W-1:0]  ex_rt,
    output logic [ADDR_W-1:0]  ex_rd,
    output logic [FUNCT_W-1:0] ex_funct,
    output logic [CTRL_W-1:0]  ex_ctrl,
    output logic               hazard_stall,
    output logic [CNT_W-1:0]   bubble_cnt,
    output logic [CNT_W-1:0]   flush_cnt
);

    logic load_in_ex;
    logic rs_match;
    logic rt_match;

    // $zero is never a real producer, so it cannot create a dependency.
    assign load_in_ex   = ex_valid && ex_ctrl[MEMREAD_BIT];
    assign rs_match     = (ex_rt == id_rs);
    assign rt_match     = id_uses_rt && (ex_rt == id_rt);
    assign hazard_stall = load_in_ex && id_valid && (ex_rt != '0)
                          && (rs_match || rt_match) && !flush_in;

    always_ff @(posedge clk) begin
        if (reset) begin
            ex_valid   <= 1'b0;
            ex_pc_incr <= '0;
            ex_rd1     <= '0;
            ex_rd2     <= '0;
            ex_imm     <= '0;
            ex_rs      <= '0;
            ex_rt      <= '0;
            ex_rd      <= '0;
            ex_funct   <= '0;
            ex_ctrl    <= '0;
            bubble_cnt <= '0;
            flush_cnt  <= '0;
        end else if (flush_in) begin
            ex_valid <= 1'b0;
            ex_ctrl  <= '0;
            if (id_valid && (flush_cnt != '1))
                flush_cnt <= flush_cnt + CNT_W'(1);
        end else if (!stall_in) begin
            if (hazard_stall) begin
                // Bubble: cleared valid/ctrl makes the held instruction load next cycle.
                ex_valid <= 1'b0;
                ex_ctrl  <= '0;
                if (bubble_cnt != '1)
                    bubble_cnt <= bubble_cnt + CNT_W'(1);
            end else begin
                ex_valid   <= id_valid;
                ex_pc_incr <= id_pc_incr;
                ex_rd1     <= id_rd1;
                ex_rd2     <= id_rd2;
                ex_imm     <= id_imm;
                ex_rs      <= id_rs;
                ex_rt      <= id_rt;
                ex_rd      <= id_rd;
                ex_funct   <= id_funct;
                ex_ctrl    <= id_valid ? id_ctrl : '0;
            end
        end
    end

endmodule

// File: doc/id_ex_pipe_stage.md
Name: id_ex_pipe_stage

Overview:
Parametrised ID/EX pipeline stage for the pipelined MIPS core. It replaces the fixed-width ID/EX register with a version that adds a valid bit, a packed control bundle, downstream stall (hold), branch/jump flush and in-stage load-use hazard detection with bubble insertion. It sits between decode and execute. It drives hazard_stall back to the PC and IF/ID registers, and provides saturating bubble and flush counters for performance debug.

Parameters:
DATA_W, 32, width of the PC+4, RD1, RD2 and immediate fields
ADDR_W, 5, width of the register specifiers rs/rt/rd
FUNCT_W, 6, width of the funct field
CTRL_W, 10, width of the packed control bundle {RegDst, ALUSrc, MemtoReg, RegWrite, MemRead, MemWrite, Branch, Jump, ALUOp[1:0]}
MEMREAD_BIT, 5, bit index of MemRead inside the control bundle
CNT_W, 16, width of each performance counter

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-high reset
flush_in  in  1  taken branch/jump: squash the instruction entering EX
stall_in  in  1  downstream stall: hold the entire stage
id_valid  in  1  decode slot holds a real instruction
id_pc_incr, id_rd1, id_rd2, id_imm  in  DATA_W each  decode datapath fields
id_rs, id_rt, id_rd  in  ADDR_W each  register specifiers
id_uses_rt  in  1  decoded instruction reads rt as a source
id_funct  in  FUNCT_W  funct field
id_ctrl  in  CTRL_W  control bundle
ex_valid  out  1  registered valid
ex_pc_incr, ex_rd1, ex_rd2, ex_imm  out  DATA_W each  registered datapath fields
ex_rs, ex_rt, ex_rd  out  ADDR_W each  registered specifiers
ex_funct  out  FUNCT_W  registered funct
ex_ctrl  out  CTRL_W  registered control bundle
hazard_stall  out  1  combinational; hold PC and IF/ID this cycle
bubble_cnt  out  CNT_W  number of load-use bubbles inserted
flush_cnt  out  CNT_W  number of valid instructions squashed

Behaviour:
- Reset (reset=1 at the clk edge): every registered output, including both counters, goes to 0. Reset takes priority over all other inputs.
- hazard_stall is asserted when all of the following hold:
  - ex_valid and ex_ctrl[MEMREAD_BIT] are 1, and id_valid is 1;
  - ex_rt is not 0;
  - ex_rt equals id_rs, or id_uses_rt is 1 and ex_rt equals id_rt;
  - flush_in is 0.
  It is purely combinational. It is also asserted while stall_in is high, which is harmless because the upstream stages hold anyway.
- Per-edge priority, with reset=0:
  1. flush_in=1: ex_valid<=0 and ex_ctrl<=0; datapath, specifier and funct registers hold. flush_cnt increments if id_valid=1. Flush overrides stall_in.
  2. stall_in=1: every register holds and no counter changes.
  3. hazard_stall=1: bubble inserted. ex_valid<=0 and ex_ctrl<=0; other fields hold; bubble_cnt increments.
  4. Otherwise (load): all fields capture their id_* inputs, ex_valid<=id_valid, and ex_ctrl<=(id_valid ? id_ctrl : 0).
- Invariant: ex_valid=0 implies ex_ctrl=0. This guarantees a bubble never writes a register or memory.
- Latency: 1 cycle from id_* to ex_* when no stall, flush or hazard occurs.
- A load-use hazard costs exactly one bubble: the inserted bubble clears ex_valid, so hazard_stall drops on the next cycle and the held instruction loads.
- Counters: unsigned and saturating at all-ones; no wrap-around.
- Register 0 never triggers a hazard.
- When reset is asserted mid-stall or mid-hazard, the next cycle starts from the empty state with hazard_stall=0.

Test Plan:
- Reset: assert reset for 2 cycles with random inputs -> all outputs 0, hazard_stall=0, both counters 0.
- Pass-through: id_valid=1, id_pc_incr=0x00000104, id_ctrl=0x0A2, id_rt=5 -> next cycle ex_pc_incr=0x104, ex_ctrl=0x0A2, ex_rt=5, ex_valid=1. Then id_valid=0 -> ex_ctrl=0.
- Load-use hazard: EX holds lw with ex_rt=8 and MemRead=1; ID presents add with id_rs=8 -> hazard_stall=1 for one cycle, ex_valid=0 next cycle, bubble_cnt=1. The add then loads on the following cycle.
- No false hazards: same lw with ex_rt=0 and id_rs=0 -> hazard_stall=0. With ex_rt=8, id_rt=8 and id_uses_rt=0 -> hazard_stall=0.
- Stall vs flush: stall_in=1 for 3 cycles -> all outputs stable and counters unchanged. Then flush_in=1 together with stall_in=1 and id_valid=1 -> ex_valid=0, ex_ctrl=0, flush_cnt=1.
- Saturation: CNT_W=2, force 5 load-use hazards -> bubble_cnt reads 1, 2, 3, 3, 3.
